// File: rtl/datagram_receiver_pkg.sv
// -----------------------------------------------------------------------------
// datagram_receiver_pkg
// Shared constants and types for the display-board datagram receiver:
//   - MESSAGE_SIZE      : width of the game-state datagram in bits
//   - SCENE_GAME_START  : datagram value presented before any frame commits
//   - LINK_CRC_POLY/BITS: CRC-8 used on the link when DATAGRAM_CRC_EN is set
//   - rx_state_t        : receive FSM states
//   - crc8_step         : one serial CRC-8 update (MSB-first register)
// -----------------------------------------------------------------------------
package datagram_receiver_pkg;

   localparam int         MESSAGE_SIZE     = 16;
   localparam int         SCENE_GAME_START = 0;
   localparam logic [7:0] LINK_CRC_POLY    = 8'h07;
   localparam int         LINK_CRC_BITS    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } rx_state_t;

   // Feedback is the register MSB xor the incoming bit, so the first bit on
   // the wire acts as the highest-degree coefficient of the message.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic       bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? LINK_CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/datagram_receiver_crc8_serial.sv
// -----------------------------------------------------------------------------
// crc8_serial
// Bit-serial CRC-8 (polynomial 0x07, init 0x00) over the payload of a link
// frame.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   clear     : restart the CRC at a new frame (init value 0x00)
//   bit_valid : bit_in is a payload bit to fold in this cycle
//   bit_in    : payload bit, in arrival order
//   crc       : running CRC of all payload bits since clear
// -----------------------------------------------------------------------------
module crc8_serial
   import datagram_receiver_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic [7:0] crc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           crc <= 8'h00;
      else if (clear)     crc <= 8'h00;
      else if (bit_valid) crc <= crc8_step(crc, bit_in);
   end

endmodule

// File: rtl/datagram_receiver_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Generic single-bit synchronizer chain for an asynchronous input.
// Ports:
//   clk  : destination clock
//   rst  : asynchronous active-low reset, loads RESET_VAL into every stage
//   d    : asynchronous input
//   q    : synchronized output, STAGES clk cycles behind d
// RESET_VAL lets an input whose idle level is high come out of reset without
// producing a spurious edge.
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= {STAGES{RESET_VAL}};
      else      sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/datagram_receiver.sv
// -----------------------------------------------------------------------------
// datagram_receiver
// Front end of the display board: deserializes the game-state datagram sent
// by the core board over a 3-wire source-synchronous link, validates each
// frame, holds the latest good one in a staging register and commits it to
// the output only on a vsync falling edge, so the quadrant renderer never
// sees a datagram change in the middle of a video frame.
//
// Build option: define DATAGRAM_CRC_EN to expect an 8-bit CRC (MSB first)
// after the payload and reject frames whose CRC does not match.
//
// Ports:
//   clk             : system clock
//   rst             : asynchronous active-low reset
//   link_frame      : async, high for the duration of a frame
//   link_strobe     : async, data valid on each rising edge
//   link_data       : async serial data, payload LSB first
//   vsync           : async active-low vertical sync from the VGA timing
//   datagram        : committed datagram
//   datagram_update : one-cycle pulse when datagram is reloaded
//   link_up         : a good frame arrived within the last TIMEOUT_CYCLES
//   frame_err_cnt   : saturating count of rejected frames
// -----------------------------------------------------------------------------
module datagram_receiver
   import datagram_receiver_pkg::*;
#(
   parameter int MSG_BITS       = MESSAGE_SIZE,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                link_frame,
   input  logic                link_strobe,
   input  logic                link_data,
   input  logic                vsync,
   output logic [MSG_BITS-1:0] datagram,
   output logic                datagram_update,
   output logic                link_up,
   output logic [7:0]          frame_err_cnt
);

`ifdef DATAGRAM_CRC_EN
   localparam int EXPECTED = MSG_BITS + LINK_CRC_BITS;
`else
   localparam int EXPECTED = MSG_BITS;
`endif
   localparam int CW = $clog2(EXPECTED + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic frame_s, strobe_s, data_s, vsync_s;
   logic frame_q, strobe_q, vsync_q;
   logic frame_rise, frame_fall, strobe_rise, vsync_fall;

   rx_state_t state, state_nxt;
   logic      frame_start, shift_en, check;

   logic [CW-1:0]       bit_cnt;
   logic                ovf;
   logic [EXPECTED-1:0] shreg;
   logic [MSG_BITS-1:0] staging;
   logic                pending;
   logic                len_ok, frame_ok, accept, reject;
   logic [TW-1:0]       to_cnt;

   // ---- input synchronizers ----
   // frame and vsync idle high through reset: a frame already in flight at
   // reset release shows no rising edge and is ignored to its end.
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_frame (
      .clk(clk), .rst(rst), .d(link_frame), .q(frame_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_strobe (
      .clk(clk), .rst(rst), .d(link_strobe), .q(strobe_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
      .clk(clk), .rst(rst), .d(link_data), .q(data_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_vsync (
      .clk(clk), .rst(rst), .d(vsync), .q(vsync_s));

   // ---- edge detection on synchronized signals ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q  <= 1'b1;
         strobe_q <= 1'b0;
         vsync_q  <= 1'b1;
      end else begin
         frame_q  <= frame_s;
         strobe_q <= strobe_s;
         vsync_q  <= vsync_s;
      end
   end

   assign frame_rise  =  frame_s  & ~frame_q;
   assign frame_fall  = ~frame_s  &  frame_q;
   assign strobe_rise =  strobe_s & ~strobe_q;
   assign vsync_fall  = ~vsync_s  &  vsync_q;

   // ---- receive FSM ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      shift_en    = 1'b0;
      check       = 1'b0;
      case (state)
         IDLE: begin
            if (frame_rise) begin
               frame_start = 1'b1;
               state_nxt   = RECV;
            end
         end
         RECV: begin
            shift_en = strobe_rise;
            if (frame_fall) state_nxt = CHECK;
         end
         CHECK: begin
            check     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- deserializer ----
   // Once bit_cnt reaches EXPECTED any further strobe marks the frame as
   // overlong; the count stops so the extra bits go nowhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
         ovf     <= 1'b0;
      end else if (frame_start) begin
         bit_cnt <= '0;
         ovf     <= 1'b0;
      end else if (shift_en) begin
         if (bit_cnt == CW'(EXPECTED)) ovf     <= 1'b1;
         else                          bit_cnt <= bit_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (frame_start) begin
         shreg <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < EXPECTED; i++) begin
            if (bit_cnt == CW'(i)) shreg[i] <= data_s;
         end
      end
   end

   // ---- frame validation ----
   assign len_ok = !ovf && (bit_cnt == CW'(EXPECTED));

`ifdef DATAGRAM_CRC_EN
   logic [7:0] crc_calc;
   logic [7:0] crc_rx;
   logic       crc_bit_valid;

   assign crc_bit_valid = shift_en && (bit_cnt < CW'(MSG_BITS));

   crc8_serial u_crc (
      .clk       (clk),
      .rst       (rst),
      .clear     (frame_start),
      .bit_valid (crc_bit_valid),
      .bit_in    (data_s),
      .crc       (crc_calc)
   );

   // The received CRC follows the payload MSB first.
   always_comb begin
      crc_rx = 8'h00;
      for (int k = 0; k < LINK_CRC_BITS; k++) begin
         crc_rx[LINK_CRC_BITS-1-k] = shreg[MSG_BITS+k];
      end
   end

   assign frame_ok = len_ok && (crc_calc == crc_rx);
`else
   assign frame_ok = len_ok;
`endif

   assign accept = check &&  frame_ok;
   assign reject = check && !frame_ok;

   // ---- staging and vsync commit ----
   always_ff @(posedge clk) begin
      if (accept) staging <= shreg[MSG_BITS-1:0];
   end

   // A commit reads staging before an accept in the same cycle overwrites it;
   // the accept then re-arms pending for the next vsync.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         datagram        <= MSG_BITS'(SCENE_GAME_START);
         datagram_update <= 1'b0;
         pending         <= 1'b0;
      end else begin
         datagram_update <= 1'b0;
         if (vsync_fall && pending) begin
            datagram        <= staging;
            datagram_update <= 1'b1;
            pending         <= 1'b0;
         end
         if (accept) pending <= 1'b1;
      end
   end

   // ---- link health ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt        <= '0;
         link_up       <= 1'b0;
         frame_err_cnt <= 8'd0;
      end else begin
         if (accept) begin
            to_cnt  <= '0;
            link_up <= 1'b1;
         end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
            link_up <= 1'b0;
         end else begin
            to_cnt <= to_cnt + TW'(1);
         end
         if (reject && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_datagram_receiver.sv
module tb_datagram_receiver;

  localparam int MSG = 16;
  localparam int TO  = 1000;
`ifdef DATAGRAM_CRC_EN
  localparam int EXP = MSG + 8;
`else
  localparam int EXP = MSG;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           link_frame = 1'b0;
  logic           link_strobe = 1'b0;
  logic           link_data = 1'b0;
  logic           vsync = 1'b1;
  logic [MSG-1:0] datagram;
  logic           datagram_update;
  logic           link_up;
  logic [7:0]     frame_err_cnt;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  // reference model state
  logic [MSG-1:0] m_dg = '0;
  logic [MSG-1:0] m_stage = '0;
  bit             m_pend = 1'b0;
  int             m_err = 0;
  int             m_upd = 0;

  datagram_receiver #(.MSG_BITS(MSG), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .link_frame(link_frame), .link_strobe(link_strobe),
    .link_data(link_data), .vsync(vsync), .datagram(datagram),
    .datagram_update(datagram_update), .link_up(link_up),
    .frame_err_cnt(frame_err_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && datagram_update) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // CRC as polynomial remainder of M(x)*x^8 mod (x^8+x^2+x+1); the first bit
  // on the wire (payload bit 0) is the highest-degree coefficient.
  function automatic logic [7:0] ref_crc(input logic [MSG-1:0] p);
    logic [MSG+7:0] r;
    r = '0;
    for (int i = 0; i < MSG; i++) r[MSG+7-i] = p[i];
    for (int d = MSG + 7; d >= 8; d--)
      if (r[d]) r[d-:9] = r[d-:9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic m_vsync();
    if (m_pend) begin
      m_dg   = m_stage;
      m_pend = 1'b0;
      m_upd++;
    end
  endtask

  task automatic m_frame(input logic [MSG-1:0] pay, input int n, input bit bad_crc);
    if (n == EXP && !bad_crc) begin
      m_stage = pay;
      m_pend  = 1'b1;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic send_bits(input logic [EXP+7:0] stream, input int from, input int to_bit);
    for (int i = from; i < to_bit; i++) begin
      link_data = stream[i];
      repeat (3) @(negedge clk);
      link_strobe = 1'b1;
      repeat (3) @(negedge clk);
      link_strobe = 1'b0;
    end
  endtask

  function automatic logic [EXP+7:0] build_stream(input logic [MSG-1:0] pay, input bit bad_crc);
    logic [EXP+7:0] s;
    logic [7:0] c;
    s = '0;
    for (int i = EXP; i < EXP + 8; i++) s[i] = 1'($urandom_range(1, 0));
    for (int i = 0; i < MSG; i++) s[i] = pay[i];
    c = ref_crc(pay);
    if (bad_crc) c[$urandom_range(7, 0)] ^= 1'b1;
`ifdef DATAGRAM_CRC_EN
    for (int k = 0; k < 8; k++) s[MSG+k] = c[7-k];
`endif
    return s;
  endfunction

  // n bits of the frame stream; vs_sim drops vsync so its synchronized edge
  // lands in the cycle the frame is judged.
  task automatic send_frame(input logic [MSG-1:0] pay, input int n, input bit bad_crc, input bit vs_sim);
    logic [EXP+7:0] s;
    s = build_stream(pay, bad_crc);
    @(negedge clk);
    link_frame = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(s, 0, n);
    repeat (3) @(negedge clk);
    link_frame = 1'b0;
    if (vs_sim) begin
      @(negedge clk);
      vsync = 1'b0;
      repeat (6) @(negedge clk);
      vsync = 1'b1;
      m_vsync();
    end
    repeat (8) @(negedge clk);
    m_frame(pay, n, bad_crc);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    vsync = 1'b1;
    repeat (6) @(negedge clk);
    m_vsync();
  endtask

  task automatic check_all(input string tag);
    check({tag, "_datagram"}, 32'(datagram), 32'(m_dg));
    check({tag, "_err_cnt"}, 32'(frame_err_cnt), 32'(m_err));
    check({tag, "_updates"}, 32'(upd_cnt), 32'(m_upd));
  endtask

  initial begin
    logic [MSG-1:0] p;
    logic [EXP+7:0] s;
    int n, sel, nf;
    bit bc;

    // reset
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_datagram", 32'(datagram), 32'h0);
    check("rst_update", 32'(datagram_update), 32'h0);
    check("rst_link_up", 32'(link_up), 32'h0);
    check("rst_err_cnt", 32'(frame_err_cnt), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // basic good frame
    send_frame(16'hA5C3, EXP, 1'b0, 1'b0);
    check("basic_link_up", 32'(link_up), 32'h1);
    check("basic_nocommit", 32'(datagram), 32'h0);
    vsync_pulse();
    check_all("basic");
    check("basic_value", 32'(datagram), 32'hA5C3);

    // short and long frames rejected
    send_frame(16'h3C3C, EXP - 1, 1'b0, 1'b0);
    send_frame(16'h4D4D, EXP + 1, 1'b0, 1'b0);
    vsync_pulse();
    check_all("len");
    check("len_err2", 32'(frame_err_cnt), 32'h2);

    // latest wins
    send_frame(16'h1111, EXP, 1'b0, 1'b0);
    send_frame(16'h2222, EXP, 1'b0, 1'b0);
    vsync_pulse();
    check_all("latest");
    check("latest_value", 32'(datagram), 32'h2222);

    // vsync edge coincides with accept
    send_frame(16'h1234, EXP, 1'b0, 1'b0);
    send_frame(16'h00FF, EXP, 1'b0, 1'b1);
    check_all("simul_a");
    check("simul_old", 32'(datagram), 32'h1234);
    vsync_pulse();
    check_all("simul_b");
    check("simul_new", 32'(datagram), 32'h00FF);

`ifdef DATAGRAM_CRC_EN
    // corrupted CRC
    send_frame(16'hA5C3, EXP, 1'b1, 1'b0);
    vsync_pulse();
    check_all("crc_bad");
    send_frame(16'hA5C3, EXP, 1'b0, 1'b0);
    vsync_pulse();
    check_all("crc_good");
`endif

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      nf = $urandom_range(2, 1);
      for (int f = 0; f < nf; f++) begin
        p   = MSG'($urandom);
        sel = $urandom_range(5, 0);
        bc  = 1'b0;
        if (sel == 0)      n = EXP - 1 - $urandom_range(3, 0);
        else if (sel == 1) n = EXP + $urandom_range(3, 1);
        else               n = EXP;
`ifdef DATAGRAM_CRC_EN
        bc = (sel == 2);
`endif
        send_frame(p, n, bc, 1'b0);
      end
      vsync_pulse();
      check_all("rand");
    end

    // timeout
    send_frame(16'h5A5A, EXP, 1'b0, 1'b0);
    vsync_pulse();
    check("to_link_up_before", 32'(link_up), 32'h1);
    repeat (TO - 100) @(negedge clk);
    check("to_link_up_still", 32'(link_up), 32'h1);
    repeat (200) @(negedge clk);
    check("to_link_down", 32'(link_up), 32'h0);
    check_all("to_held");

    // reset in the middle of a frame
    s = build_stream(16'h9999, 1'b0);
    @(negedge clk);
    link_frame = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(s, 0, 8);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_dg = '0; m_pend = 1'b0; m_err = 0;
    check("mid_rst_datagram", 32'(datagram), 32'h0);
    check("mid_rst_update", 32'(datagram_update), 32'h0);
    check("mid_rst_link_up", 32'(link_up), 32'h0);
    check("mid_rst_err_cnt", 32'(frame_err_cnt), 32'h0);
    rst = 1'b1;
    send_bits(s, 8, EXP);
    repeat (3) @(negedge clk);
    link_frame = 1'b0;
    repeat (10) @(negedge clk);
    vsync_pulse();
    check_all("after_rst_tail");
    send_frame(16'hBEEF, EXP, 1'b0, 1'b0);
    vsync_pulse();
    check_all("after_rst_good");
    check("after_rst_value", 32'(datagram), 32'hBEEF);
    check("after_rst_link_up", 32'(link_up), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datagram_receiver.md
Name: datagram_receiver

Overview:
- Display-board front end that receives the core board's game-state datagram over a 3-wire source-synchronous link (frame, strobe, data).
- Deserializes and validates each frame, double-buffers it, and commits a new datagram only at the start of vertical sync, so the downstream quadrant output interface never renders a torn frame.
- Also reports link health.

Parameters:
- MSG_BITS, MESSAGE_SIZE: payload width in bits; equals the datagram width consumed downstream.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers, minimum 2.
- TIMEOUT_CYCLES, 2_000_000: clk cycles with no good frame before link_up drops (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- link_frame  in  1  asynchronous; high for the whole frame.
- link_strobe  in  1  asynchronous; data is valid on each rising edge.
- link_data  in  1  asynchronous serial bit, LSB first.
- vsync  in  1  from the VGA timing generator (25 MHz domain, slow edges); active-low pulse.
- datagram  out  MSG_BITS  committed datagram.
- datagram_update  out  1  one-cycle pulse when datagram changes.
- link_up  out  1  a good frame was received within the last TIMEOUT_CYCLES.
- frame_err_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Reset (async assert, sync release): datagram = 0 (SCENE_GAME_START), datagram_update = 0, link_up = 0, frame_err_cnt = 0. FSM goes to IDLE, pending flag cleared.
- Synchronization:
  - link_frame, link_strobe, link_data and vsync each pass through SYNC_STAGES flops.
  - Edge detection runs on the synchronized values.
  - Data is sampled on the synchronized strobe rising edge, delayed identically to the strobe.
- FSM states:
  - IDLE: on frame rising edge, clear the shift register and bit counter, go to RECV.
  - RECV: each strobe rising edge shifts in link_data at position bit_cnt; bit_cnt increments. On frame falling edge, go to CHECK.
  - CHECK (one cycle): accept only if bit_cnt == EXPECTED (MSG_BITS, or MSG_BITS+8 with CRC) and, with CRC, the CRC matches.
    - Accept: staging <= shift register, pending <= 1, timeout counter cleared, link_up <= 1.
    - Reject: frame_err_cnt increments (holds at 255); staging and pending are untouched.
    - Either way, go to IDLE.
- Overflow: a strobe edge with bit_cnt == EXPECTED sets an overflow flag. Further bits are dropped and the frame is rejected in CHECK.
- Strobe edges in IDLE are ignored.
- Latest wins: a good frame arriving while pending is still set overwrites staging.
- Commit:
  - On the synchronized vsync falling edge with pending = 1: datagram <= staging, pending <= 0, datagram_update = 1 in the following cycle.
  - With no pending frame, datagram holds.
- Simultaneous vsync edge and CHECK accept in the same cycle: the commit uses the old staging; the new frame stays pending for the next vsync.
- Latency: a good frame appears on datagram 1–2 cycles after the first vsync falling edge that follows its CHECK cycle.
- Timeout: the counter saturates at TIMEOUT_CYCLES. On reaching it, link_up <= 0; datagram keeps its last value.
- Reset mid-frame: partial data is discarded. After release, the FSM waits in IDLE for a fresh frame rising edge (the remainder of an in-flight frame is ignored).

Optional Feature:
- Macro: DATAGRAM_CRC_EN.
- Defined:
  - Frame = MSG_BITS payload followed by 8 CRC bits.
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, computed serially over payload bits in arrival order.
  - The received CRC is sent MSB first; a mismatch rejects the frame.
- Undefined: frame = MSG_BITS; only length and overflow are checked; no CRC logic is synthesized.

Decomposition:
- Shared package gets:
  - the rx FSM state typedef (IDLE, RECV, CHECK);
  - LINK_CRC_POLY = 8'h07 and LINK_CRC_BITS = 8;
  - MESSAGE_SIZE, which already lives in the existing constants.
- Sub-module crc8_serial: clear, bit_valid, bit_in in; crc out. Instantiated only under DATAGRAM_CRC_EN.
- The synchronizer is a small generic sync_ff instantiated per input.

Test Plan (MSG_BITS=16, TIMEOUT_CYCLES=1000, CRC disabled unless stated):
- Send 16'hA5C3 LSB first, then pulse vsync low → datagram = 16'hA5C3 with one datagram_update pulse; link_up = 1; frame_err_cnt = 0.
- Send 15 bits, then 17 bits → both rejected: frame_err_cnt = 2, datagram unchanged, no update pulse.
- Send 16'h1111 then 16'h2222 with no vsync in between, then one vsync → datagram = 16'h2222 and exactly one update pulse.
- Accept 16'h00FF in the same cycle as a vsync falling edge, with 16'h1234 already pending → datagram = 16'h1234 now, 16'h00FF after the next vsync.
- After a good frame, idle 1000 cycles → link_up = 0 and datagram held; assert rst mid-frame → all outputs 0, next full frame accepted.
- DATAGRAM_CRC_EN: 16'hA5C3 with a correct CRC is accepted; the same frame with one flipped CRC bit leaves datagram unchanged and frame_err_cnt = 1.
